// File: rtl/dsm_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// dsm_stream_ctrl_if
// Wishbone (pipelined, single-beat) register bus used by dsm_stream_ctrl.
//   i_wb_cyc, i_wb_stb, i_wb_we : cycle, strobe, write enable (master -> slave)
//   i_wb_addr[31:0]             : byte address                (master -> slave)
//   i_wb_data[31:0]             : write data                  (master -> slave)
//   o_wb_ack                    : access acknowledge          (slave -> master)
//   o_wb_stall                  : stall, always 0 here        (slave -> master)
//   o_wb_data[31:0]             : read data, valid with ack   (slave -> master)
// Signal names keep the slave-side i_/o_ prefixes so the block ports read the
// same as the register map documentation.
// -----------------------------------------------------------------------------
interface dsm_stream_ctrl_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_stall, o_wb_data
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_stall, o_wb_data
    );
endinterface

// File: rtl/dsm_stream_ctrl.sv
// -----------------------------------------------------------------------------
// dsm_stream_ctrl
// Feeds 7-bit samples from a small FIFO into a delta-sigma modulator datapath
// at a programmable sample rate, and captures the datapath output code on
// every sample tick. Software fills the FIFO and controls the streamer via a
// 32-byte Wishbone register window at BASE_ADDR.
//
// Ports:
//   clk          : sole clock, rising edge
//   reset        : asynchronous, active-high
//   wb           : Wishbone slave (dsm_stream_ctrl_if.slave)
//   o_dsm_data   : sample presented to the DSM input register
//   o_dsm_load   : one-cycle strobe, DSM captures o_dsm_data on it
//   i_dsm_out    : DSM output code, captured into CAPT on each tick
//   o_irq        : level interrupt request
//
// Register map (byte offsets):
//   0x00 CTRL   b0 EN, b1 HOLD_LAST, b2 FLUSH (write-only, self-clearing),
//               b3 IRQ_MASK
//   0x04 DIV    sample period minus one (DIV_W bits)
//   0x08 DATA   write pushes b[6:0] into the FIFO
//   0x0C STATUS b[4:0] level, b5 full, b6 empty, b7 underflow (W1C),
//               b8 overflow (W1C), b[10:9] state
//   0x10 CAPT   DSM output code captured at the last tick
//
// Build option: define DSM_STREAM_IRQ_EN to enable the interrupt logic
// (IRQ_MASK storage and o_irq). Without it o_irq is tied low and CTRL.b3
// reads 0.
// -----------------------------------------------------------------------------
module dsm_stream_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
    parameter int          FIFO_DEPTH = 8,
    parameter int          DIV_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    dsm_stream_ctrl_if.slave  wb,
    output logic [6:0]        o_dsm_data,
    output logic              o_dsm_load,
    input  logic [4:0]        i_dsm_out,
    output logic              o_irq
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_DIV    = 3'd1;
    localparam logic [2:0] OFF_DATA   = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_CAPT   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_UNDERRUN = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // ---------------------------------------------------------------- storage
    logic             en_reg;
    logic             hold_last_reg;
    logic             irq_mask_reg;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [4:0]       capt_reg;
    logic             underflow_reg;
    logic             overflow_reg;
    logic [6:0]       last_sample_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [6:0]       mem [FIFO_DEPTH];

    // ------------------------------------------------------------ bus decode
    logic       bus_req, in_window, acc, wr_en, rd_en;
    logic [2:0] reg_off;
    logic       wr_ctrl, wr_div, wr_data, wr_status;
    logic [31:0] rd_word;

    assign bus_req   = wb.i_wb_cyc & wb.i_wb_stb;
    assign in_window = (wb.i_wb_addr[31:5] == BASE_ADDR[31:5]);
    assign acc       = bus_req & in_window;
    assign wr_en     = acc & wb.i_wb_we;
    assign rd_en     = acc & ~wb.i_wb_we;
    assign reg_off   = wb.i_wb_addr[4:2];

    assign wr_ctrl   = wr_en & (reg_off == OFF_CTRL);
    assign wr_div    = wr_en & (reg_off == OFF_DIV);
    assign wr_data   = wr_en & (reg_off == OFF_DATA);
    assign wr_status = wr_en & (reg_off == OFF_STATUS);

    // Byte lanes are not used and only the low bits of write data matter per
    // register; fold the rest into one sink so the whole bus counts as read.
    logic unused_bus;
    assign unused_bus = ^{wb.i_wb_addr[1:0], wb.i_wb_data};

    assign wb.o_wb_stall = 1'b0;

    // ---------------------------------------------------------- control path
    logic en_next;
    logic flush;
    logic tick;
    logic fifo_full, fifo_empty, fifo_empty_eff;
    logic push, pop;
    logic udf_set, ovf_set;

    // EN as it will be after this cycle; the FSM reacts to the write directly
    // so IDLE->RUN and RUN->IDLE both land on the cycle after the write.
    assign en_next = wr_ctrl ? wb.i_wb_data[0] : en_reg;
    assign flush   = wr_ctrl & wb.i_wb_data[2];

    assign fifo_full  = (level_reg == FULL_LVL);
    assign fifo_empty = (level_reg == '0);
    // A flush in the same cycle makes a coinciding tick see an empty FIFO.
    assign fifo_empty_eff = fifo_empty | flush;

    assign pop     = tick & ~fifo_empty_eff;
    // Full FIFO still accepts a push when a pop frees the head slot this cycle.
    assign push    = wr_data & ~flush & (~fifo_full | pop);
    assign ovf_set = wr_data & ~flush & fifo_full & ~pop;
    assign udf_set = tick & fifo_empty_eff;

    // FSM next-state, period counter and tick generation.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tick       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (en_next) begin
                    state_next = S_RUN;
                    cnt_next   = div_reg;
                end
            end
            S_RUN, S_UNDERRUN: begin
                if (cnt_reg == '0) begin
                    tick       = 1'b1;
                    cnt_next   = div_reg;
                    state_next = fifo_empty_eff ? S_UNDERRUN : S_RUN;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
                // A tick on the EN-clearing cycle still pops/loads above;
                // only the next state is overridden.
                if (!en_next) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ------------------------------------------------------ config registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_reg        <= 1'b0;
            hold_last_reg <= 1'b0;
            div_reg       <= '0;
        end else begin
            en_reg <= en_next;
            if (wr_ctrl) begin
                hold_last_reg <= wb.i_wb_data[1];
            end
            if (wr_div) begin
                div_reg <= wb.i_wb_data[DIV_W-1:0];
            end
        end
    end

    // Sticky flags: a set in the same cycle as a W1C wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            underflow_reg <= udf_set | (underflow_reg & ~(wr_status & wb.i_wb_data[7]));
            overflow_reg  <= ovf_set | (overflow_reg  & ~(wr_status & wb.i_wb_data[8]));
        end
    end

    // ------------------------------------------------------------------ FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_ONE;
                2'b01:   level_reg <= level_reg - LVL_ONE;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Sample storage; no reset so it maps onto plain RAM. When full with a
    // simultaneous pop, the write slot equals the head slot: the read below
    // still returns the old head because both are sampled on the same edge.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wb.i_wb_data[6:0];
        end
    end

    // ------------------------------------------------------------ DSM feed
    // Strobe and data are registered together so the strobe always coincides
    // with valid data. Consequently a tick that completes on the EN-clearing
    // cycle shows its strobe in the first IDLE cycle; afterwards the strobe
    // stays low for as long as the block is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_dsm_load      <= 1'b0;
            o_dsm_data      <= '0;
            last_sample_reg <= '0;
            capt_reg        <= '0;
        end else begin
            o_dsm_load <= tick;
            if (tick) begin
                capt_reg <= i_dsm_out;
                if (pop) begin
                    o_dsm_data      <= mem[rd_ptr_reg];
                    last_sample_reg <= mem[rd_ptr_reg];
                end else begin
                    o_dsm_data <= hold_last_reg ? last_sample_reg : 7'd0;
                end
            end
        end
    end

    // ----------------------------------------------------------- interrupt
`ifdef DSM_STREAM_IRQ_EN
    localparam logic [LVL_W-1:0] HALF_LVL = LVL_W'(FIFO_DEPTH / 2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask_reg <= 1'b0;
            o_irq        <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_mask_reg <= wb.i_wb_data[3];
            end
            o_irq <= irq_mask_reg & en_reg & ((level_reg <= HALF_LVL) | underflow_reg);
        end
    end
`else
    assign irq_mask_reg = 1'b0;
    assign o_irq        = 1'b0;
`endif

    // ------------------------------------------------------------- readback
    always_comb begin
        rd_word = '0;
        case (reg_off)
            OFF_CTRL: begin
                rd_word[0] = en_reg;
                rd_word[1] = hold_last_reg;
                rd_word[3] = irq_mask_reg;
            end
            OFF_DIV: begin
                rd_word[DIV_W-1:0] = div_reg;
            end
            OFF_STATUS: begin
                rd_word[LVL_W-1:0] = level_reg;
                rd_word[5]         = fifo_full;
                rd_word[6]         = fifo_empty;
                rd_word[7]         = underflow_reg;
                rd_word[8]         = overflow_reg;
                rd_word[10:9]      = state_reg;
            end
            OFF_CAPT: begin
                rd_word[4:0] = capt_reg;
            end
            default: begin
                rd_word = '0;
            end
        endcase
    end

    // Every in-window access is acked on the following cycle; read data is
    // returned with the ack and is zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb.o_wb_ack  <= 1'b0;
            wb.o_wb_data <= '0;
        end else begin
            wb.o_wb_ack  <= acc;
            wb.o_wb_data <= rd_en ? rd_word : 32'd0;
        end
    end

endmodule

// File: tb/tb_dsm_stream_ctrl.sv
`timescale 1ns/1ps
module tb_dsm_stream_ctrl;

    localparam logic [31:0] BASE     = 32'h3000_0100;
    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_DIV    = BASE + 32'h04;
    localparam logic [31:0] A_DATA   = BASE + 32'h08;
    localparam logic [31:0] A_STATUS = BASE + 32'h0C;
    localparam logic [31:0] A_CAPT   = BASE + 32'h10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] o_dsm_data;
    logic       o_dsm_load;
    logic [4:0] i_dsm_out = 5'd0;
    logic       o_irq;

    int checks   = 0;
    int failures = 0;

    dsm_stream_ctrl_if wb();

    dsm_stream_ctrl #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8),
        .DIV_W      (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb         (wb),
        .o_dsm_data (o_dsm_data),
        .o_dsm_load (o_dsm_load),
        .i_dsm_out  (i_dsm_out),
        .o_irq      (o_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ bus tasks
    // All tasks are entered and left on a falling clock edge.
    task automatic bus_idle();
        wb.i_wb_cyc  = 1'b0;
        wb.i_wb_stb  = 1'b0;
        wb.i_wb_we   = 1'b0;
        wb.i_wb_addr = 32'd0;
        wb.i_wb_data = 32'd0;
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data, output logic ack);
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_stb  = 1'b1;
        wb.i_wb_we   = 1'b1;
        wb.i_wb_addr = addr;
        wb.i_wb_data = data;
        @(negedge clk);
        ack = wb.o_wb_ack;
        $display("[%0t] wr addr=%h data=%h ack=%0b", $time, addr, data, ack);
        bus_idle();
    endtask

    task automatic wb_read(input logic [31:0] addr, output logic [31:0] data, output logic ack);
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_stb  = 1'b1;
        wb.i_wb_we   = 1'b0;
        wb.i_wb_addr = addr;
        @(negedge clk);
        ack  = wb.o_wb_ack;
        data = wb.o_wb_data;
        $display("[%0t] rd addr=%h data=%h ack=%0b", $time, addr, data, ack);
        bus_idle();
    endtask

    task automatic wait_load(input int max_cyc, output logic [6:0] data, output int cyc, output bit got);
        got  = 1'b0;
        cyc  = 0;
        data = '0;
        while (!got && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (o_dsm_load === 1'b1) begin
                got  = 1'b1;
                data = o_dsm_data;
            end
        end
        $display("[%0t] load got=%0b data=%0d after %0d cycles", $time, got, data, cyc);
    endtask

    task automatic do_reset();
        bus_idle();
        i_dsm_out = 5'd0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        logic [31:0] rd;
        logic        ack;
        reset = 1'b1;
        bus_idle();
        @(negedge clk);
        checks++;
        if ({o_dsm_load, o_dsm_data, wb.o_wb_ack, wb.o_wb_data, o_irq} !== 41'd0) begin
            failures++;
            $display("FAIL reset_outputs got load=%0b data=%0d ack=%0b rdata=%h irq=%0b want all 0",
                     o_dsm_load, o_dsm_data, wb.o_wb_ack, wb.o_wb_data, o_irq);
        end
        do_reset();
        wb_read(A_CTRL, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL reset_ctrl got ack=%0b data=%h want ack=1 data=0", ack, rd);
        end
        wb_read(A_DIV, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL reset_div got ack=%0b data=%h want ack=1 data=0", ack, rd);
        end
        wb_read(A_STATUS, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h40}) begin
            failures++; $display("FAIL reset_status got ack=%0b data=%h want ack=1 data=00000040", ack, rd);
        end
        wb_read(A_CAPT, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL reset_capt got ack=%0b data=%h want ack=1 data=0", ack, rd);
        end
        // DIV keeps only its 16 low bits.
        wb_write(A_DIV, 32'h1234_0003, ack);
        wb_read(A_DIV, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h3}) begin
            failures++; $display("FAIL div_readback got ack=%0b data=%h want ack=1 data=00000003", ack, rd);
        end
        // IRQ build option off: mask bit not stored, irq stays low.
        wb_write(A_CTRL, 32'h0000_000B, ack);
        wb_read(A_CTRL, rd, ack);
        checks++;
        if ({ack, rd, o_irq} !== {1'b1, 32'h3, 1'b0}) begin
            failures++; $display("FAIL ctrl_readback got ack=%0b data=%h irq=%0b want ack=1 data=00000003 irq=0", ack, rd, o_irq);
        end
    endtask

    task automatic test_stream();
        logic [31:0] rd;
        logic        ack;
        logic [6:0]  d;
        int          cyc;
        bit          got;
        logic [6:0]  exp_ld [4];
        exp_ld[0] = 7'd10; exp_ld[1] = 7'd20; exp_ld[2] = 7'd30; exp_ld[3] = 7'd0;
        do_reset();
        wb_write(A_DIV, 32'd3, ack);
        wb_write(A_DATA, 32'd10, ack);
        wb_write(A_DATA, 32'd20, ack);
        wb_write(A_DATA, 32'd30, ack);
        wb_write(A_CTRL, 32'h1, ack);
        for (int i = 0; i < 4; i++) begin
            wait_load(20, d, cyc, got);
            checks++;
            if ({got, d} !== {1'b1, exp_ld[i]}) begin
                failures++; $display("FAIL stream_load%0d got valid=%0b data=%0d want valid=1 data=%0d", i, got, d, exp_ld[i]);
            end
            checks++;
            if (cyc != 4) begin
                failures++; $display("FAIL stream_period%0d got %0d cycles want 4", i, cyc);
            end
        end
        wb_read(A_STATUS, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h4C0}) begin
            failures++; $display("FAIL stream_underrun_status got ack=%0b data=%h want ack=1 data=000004c0", ack, rd);
        end
    endtask

    task automatic test_hold_last();
        logic [31:0] rd;
        logic        ack;
        logic [6:0]  d;
        int          cyc;
        bit          got;
        logic [6:0]  exp_ld [8];
        exp_ld[0] = 7'd10; exp_ld[1] = 7'd20; exp_ld[2] = 7'd30; exp_ld[3] = 7'd30;
        exp_ld[4] = 7'd30; exp_ld[5] = 7'd0;  exp_ld[6] = 7'd0;  exp_ld[7] = 7'd5;
        do_reset();
        wb_write(A_DIV, 32'd3, ack);
        wb_write(A_DATA, 32'd10, ack);
        wb_write(A_DATA, 32'd20, ack);
        wb_write(A_DATA, 32'd30, ack);
        wb_write(A_CTRL, 32'h3, ack);
        for (int i = 0; i < 8; i++) begin
            if (i == 5) wb_write(A_CTRL, 32'h1, ack);  // HOLD_LAST off
            if (i == 7) wb_write(A_DATA, 32'd5, ack);  // refill while underrunning
            wait_load(20, d, cyc, got);
            checks++;
            if ({got, d} !== {1'b1, exp_ld[i]}) begin
                failures++; $display("FAIL hold_load%0d got valid=%0b data=%0d want valid=1 data=%0d", i, got, d, exp_ld[i]);
            end
        end
        wb_read(A_STATUS, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h2C0}) begin
            failures++; $display("FAIL hold_recover_status got ack=%0b data=%h want ack=1 data=000002c0", ack, rd);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic        ack;
        do_reset();
        for (int i = 1; i <= 9; i++) wb_write(A_DATA, 32'(i), ack);
        wb_read(A_STATUS, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h128}) begin
            failures++; $display("FAIL overflow_status got ack=%0b data=%h want ack=1 data=00000128", ack, rd);
        end
        wb_write(A_STATUS, 32'h100, ack);
        wb_read(A_STATUS, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h028}) begin
            failures++; $display("FAIL overflow_w1c got ack=%0b data=%h want ack=1 data=00000028", ack, rd);
        end
    endtask

    // Runs on the full FIFO left by test_overflow (entries 1..8).
    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        ack;
        logic [6:0]  exp_d;
        wb_write(A_DIV, 32'd0, ack);
        wb_write(A_CTRL, 32'h1, ack);
        for (int i = 0; i < 10; i++) begin
            wb_write(A_DATA, 32'(40 + i), ack);
            exp_d = (i < 8) ? 7'(i + 1) : 7'(40 + i - 8);
            checks++;
            if ({ack, o_dsm_load, o_dsm_data} !== {1'b1, 1'b1, exp_d}) begin
                failures++; $display("FAIL b2b_push%0d got ack=%0b load=%0b data=%0d want ack=1 load=1 data=%0d",
                                     i, ack, o_dsm_load, o_dsm_data, exp_d);
            end
        end
        wb_read(A_STATUS, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h228}) begin
            failures++; $display("FAIL b2b_status got ack=%0b data=%h want ack=1 data=00000228", ack, rd);
        end
    endtask

    // Block is still running with DIV=0, so every cycle is a tick.
    task automatic test_capture();
        logic [31:0] rd;
        logic        ack;
        i_dsm_out = 5'd17;
        @(negedge clk);
        wb_read(A_CAPT, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'd17}) begin
            failures++; $display("FAIL capt_read got ack=%0b data=%h want ack=1 data=00000011", ack, rd);
        end
        wb_read(BASE + 32'h14, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'd0}) begin
            failures++; $display("FAIL unmapped_read got ack=%0b data=%h want ack=1 data=0", ack, rd);
        end
        wb_read(BASE + 32'h20, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b0, 32'd0}) begin
            failures++; $display("FAIL outside_read got ack=%0b data=%h want ack=0 data=0", ack, rd);
        end
    endtask

    task automatic test_window();
        logic [31:0] rd;
        logic        ack;
        do_reset();
        wb_write(BASE + 32'h28, 32'd99, ack);  // DATA offset, but outside the window
        checks++;
        if (ack !== 1'b0) begin
            failures++; $display("FAIL outside_write_ack got %0b want 0", ack);
        end
        wb_write(BASE + 32'h18, 32'hFFFF_FFFF, ack);
        checks++;
        if (ack !== 1'b1) begin
            failures++; $display("FAIL unmapped_write_ack got %0b want 1", ack);
        end
        wb_read(A_STATUS, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h040}) begin
            failures++; $display("FAIL window_no_side_effect got ack=%0b data=%h want ack=1 data=00000040", ack, rd);
        end
    endtask

    task automatic test_flush();
        logic [31:0] rd;
        logic        ack;
        do_reset();
        wb_write(A_DATA, 32'd1, ack);
        wb_write(A_DATA, 32'd2, ack);
        wb_write(A_DATA, 32'd3, ack);
        wb_read(A_STATUS, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h003}) begin
            failures++; $display("FAIL flush_pre_status got ack=%0b data=%h want ack=1 data=00000003", ack, rd);
        end
        wb_write(A_CTRL, 32'h4, ack);
        wb_read(A_STATUS, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h040}) begin
            failures++; $display("FAIL flush_status got ack=%0b data=%h want ack=1 data=00000040", ack, rd);
        end
        wb_read(A_CTRL, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL flush_selfclear got ack=%0b data=%h want ack=1 data=0", ack, rd);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] rd;
        logic        ack;
        logic [6:0]  d;
        int          cyc;
        bit          got;
        do_reset();
        wb_write(A_DIV, 32'd3, ack);
        for (int i = 0; i < 7; i++) wb_write(A_DATA, 32'(20 + i), ack);
        wb_write(A_CTRL, 32'h1, ack);
        wait_load(20, d, cyc, got);
        wb_read(A_STATUS, rd, ack);
        checks++;
        if ({got, d, ack, rd} !== {1'b1, 7'd20, 1'b1, 32'h206}) begin
            failures++; $display("FAIL mid_first_load got valid=%0b data=%0d ack=%0b status=%h want 1 20 1 00000206",
                                 got, d, ack, rd);
        end
        wait_load(20, d, cyc, got);
        checks++;
        if ({got, o_dsm_load, o_dsm_data} !== {1'b1, 1'b1, 7'd21}) begin
            failures++; $display("FAIL mid_second_load got valid=%0b load=%0b data=%0d want 1 1 21", got, o_dsm_load, o_dsm_data);
        end
        // Start a read, then hit reset between clock edges.
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_stb  = 1'b1;
        wb.i_wb_we   = 1'b0;
        wb.i_wb_addr = A_STATUS;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({o_dsm_load, o_dsm_data, wb.o_wb_ack, wb.o_wb_data, o_irq} !== 41'd0) begin
            failures++; $display("FAIL async_reset got load=%0b data=%0d ack=%0b rdata=%h irq=%0b want all 0",
                                 o_dsm_load, o_dsm_data, wb.o_wb_ack, wb.o_wb_data, o_irq);
        end
        @(negedge clk);
        checks++;
        if (wb.o_wb_ack !== 1'b0) begin
            failures++; $display("FAIL reset_inflight_ack got %0b want 0", wb.o_wb_ack);
        end
        bus_idle();
        reset = 1'b0;
        wb_read(A_STATUS, rd, ack);
        checks++;
        if ({ack, rd} !== {1'b1, 32'h040}) begin
            failures++; $display("FAIL post_reset_status got ack=%0b data=%h want ack=1 data=00000040", ack, rd);
        end
    endtask

    initial begin
        bus_idle();
        reset = 1'b1;
        test_reset();
        test_stream();
        test_hold_last();
        test_overflow();
        test_back_to_back();
        test_capture();
        test_window();
        test_flush();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
